scariv_lsu_replay_queue_mp: RTL and testbench

Multi-port, age-ordered LSU replay queue. Captures load/store ops rejected by the LSU EX2 stage with a hazard type and a hazard bit-vector. Each entry is held until its hazard resolves, then reissued to the LSU pipe, oldest-first. It supports PUSH_NUM hazard pushes per cycle, same-cycle wakeup bypass and immediate reclaim of flushed entries. It sits between the LSU EX2 hazard output and the LSU pipe request arbiter.

---
 rtl/scariv_lsu_replay_queue_mp_if.sv | 35 +++
 rtl/scariv_lsu_replay_queue_mp.sv | 192 +++++++++++++++++++
 tb/tb_scariv_lsu_replay_queue_mp.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scariv_lsu_replay_queue_mp_if.sv
// Push-side and replay-request handshake bundle for the LSU replay queue.
// The master side is the EX2 hazard producer together with the LSU pipe arbiter.
interface scariv_lsu_replay_queue_mp_if #(
   parameter int PUSH_NUM = 2,
   parameter int HAZ_W    = 8,
   parameter int CMT_W    = 6,
   parameter int GRP_W    = 4,
   parameter int PLD_W    = 64
);
   logic [PUSH_NUM-1:0]            i_push_valid;
   logic [PUSH_NUM-1:0][CMT_W-1:0] i_push_cmt_id;
   logic [PUSH_NUM-1:0][GRP_W-1:0] i_push_grp_id;
   logic [PUSH_NUM-1:0][2:0]       i_push_haz_typ;
   logic [PUSH_NUM-1:0][HAZ_W-1:0] i_push_haz_idx;
   logic [PUSH_NUM-1:0][PLD_W-1:0] i_push_payload;

   logic             o_req_valid;
   logic             i_req_ready;
   logic [CMT_W-1:0] o_req_cmt_id;
   logic [GRP_W-1:0] o_req_grp_id;
   logic [2:0]       o_req_haz_typ;
   logic [PLD_W-1:0] o_req_payload;

   modport master (
      output i_push_valid, i_push_cmt_id, i_push_grp_id, i_push_haz_typ,
             i_push_haz_idx, i_push_payload, i_req_ready,
      input  o_req_valid, o_req_cmt_id, o_req_grp_id, o_req_haz_typ, o_req_payload
   );

   modport slave (
      input  i_push_valid, i_push_cmt_id, i_push_grp_id, i_push_haz_typ,
             i_push_haz_idx, i_push_payload, i_req_ready,
      output o_req_valid, o_req_cmt_id, o_req_grp_id, o_req_haz_typ, o_req_payload
   );
endinterface

// File: rtl/scariv_lsu_replay_queue_mp.sv
// Age-ordered multi-port replay queue: holds LSU ops rejected at EX2 until their
// hazard vector clears, then reissues the oldest ready entry to the LSU pipe.
module scariv_lsu_replay_queue_mp #(
   parameter int DEPTH     = 16,
   parameter int PUSH_NUM  = 2,
   parameter int HAZ_W     = 8,
   parameter int CMT_W     = 6,
   parameter int GRP_W     = 4,
   parameter int PLD_W     = 64,
   parameter int AF_MARGIN = 4
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   scariv_lsu_replay_queue_mp_if.slave  bus,
   output logic                         o_full,
   output logic                         o_almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   input  logic [HAZ_W-1:0]             i_stq_resolve,
   input  logic                         i_missu_resolve_valid,
   input  logic [HAZ_W-1:0]             i_missu_resolve_oh,
   input  logic                         i_missu_full,
   input  logic                         i_missu_empty,
   input  logic                         i_st_buffer_empty,
   input  logic [CMT_W-1:0]             i_oldest_cmt_id,
   input  logic [GRP_W-1:0]             i_oldest_grp_id,
   input  logic                         i_flush_all,
   input  logic                         i_br_flush_valid,
   input  logic [CMT_W-1:0]             i_br_flush_cmt_id,
   input  logic [GRP_W-1:0]             i_br_flush_grp_id
);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PRT_W = (PUSH_NUM > 1) ? $clog2(PUSH_NUM) : 1;

   localparam logic [2:0] TYP_STQ            = 3'd1;
   localparam logic [2:0] TYP_MISSU_ASSIGNED = 3'd2;
   localparam logic [2:0] TYP_MISSU_FULL     = 3'd3;
   localparam logic [2:0] TYP_RMW_ORDER      = 3'd4;

   logic [DEPTH-1:0]            valid_q, valid_n;
   logic [DEPTH-1:0][DEPTH-1:0] age_q, age_n;
   logic [DEPTH-1:0][CMT_W-1:0] cmt_q;
   logic [DEPTH-1:0][GRP_W-1:0] grp_q;
   logic [DEPTH-1:0][2:0]       typ_q;
   logic [DEPTH-1:0][HAZ_W-1:0] haz_q, haz_n;
   logic [DEPTH-1:0][PLD_W-1:0] pld_q;

   logic [DEPTH-1:0]               ready, sel, free, alloc_vec;
   logic [DEPTH-1:0][PRT_W-1:0]    alloc_port;
   logic [PUSH_NUM-1:0]            alloc_en;
   logic [PUSH_NUM-1:0][IDX_W-1:0] alloc_idx;
   logic [PUSH_NUM-1:0][HAZ_W-1:0] push_haz;
   logic [CNT_W-1:0]               cnt_n;
   logic                           issue;

   function automatic logic [HAZ_W-1:0] resolve(input logic [2:0] typ, input logic [HAZ_W-1:0] h,
                                                input logic [CMT_W-1:0] cmt, input logic [GRP_W-1:0] grp);
      logic [HAZ_W-1:0] r;
      r = h;
      case (typ)
         TYP_STQ:            r = h & ~i_stq_resolve;
         TYP_MISSU_ASSIGNED: if (i_missu_resolve_valid) r = h & ~i_missu_resolve_oh;
         TYP_MISSU_FULL:     if (!i_missu_full) r = '0;
         TYP_RMW_ORDER:      if (cmt == i_oldest_cmt_id && grp == i_oldest_grp_id &&
                                 i_st_buffer_empty && i_missu_empty) r = '0;
         default:            r = '0;
      endcase
      return r;
   endfunction

   // MSB of cmt_id is the wrap bit: crossing it reverses the low-bit ordering
   function automatic logic br_kill(input logic [CMT_W-1:0] cmt, input logic [GRP_W-1:0] grp);
      logic [CMT_W-2:0] lo, flo;
      logic             yng;
      lo  = cmt[CMT_W-2:0];
      flo = i_br_flush_cmt_id[CMT_W-2:0];
      if (cmt[CMT_W-1] != i_br_flush_cmt_id[CMT_W-1]) yng = (lo < flo);
      else if (lo != flo)                             yng = (lo > flo);
      else                                            yng = (grp > i_br_flush_grp_id);
      return i_br_flush_valid && yng;
   endfunction

   // age_q[j][i] set means entry j is older than entry i
   always_comb begin
      ready = '0;
      sel   = '0;
      for (int i = 0; i < DEPTH; i++) ready[i] = valid_q[i] && (haz_q[i] == '0);
      for (int i = 0; i < DEPTH; i++) begin
         sel[i] = ready[i];
         for (int j = 0; j < DEPTH; j++) if (ready[j] && age_q[j][i]) sel[i] = 1'b0;
      end
   end

   always_comb begin
      bus.o_req_valid   = |ready;
      bus.o_req_cmt_id  = '0;
      bus.o_req_grp_id  = '0;
      bus.o_req_haz_typ = '0;
      bus.o_req_payload = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel[i]) begin
            bus.o_req_cmt_id  = cmt_q[i];
            bus.o_req_grp_id  = grp_q[i];
            bus.o_req_haz_typ = typ_q[i];
            bus.o_req_payload = pld_q[i];
         end
      end
   end

   assign issue = bus.o_req_valid && bus.i_req_ready;

   always_comb begin
      free       = ~valid_q;
      alloc_en   = '0;
      alloc_idx  = '0;
      alloc_vec  = '0;
      alloc_port = '0;
      push_haz   = '0;
      for (int p = 0; p < PUSH_NUM; p++) begin
         if (bus.i_push_valid[p] && !i_flush_all && !br_kill(bus.i_push_cmt_id[p], bus.i_push_grp_id[p])) begin
            for (int i = DEPTH-1; i >= 0; i--) begin
               if (free[i]) begin
                  alloc_idx[p] = IDX_W'(i);
                  alloc_en[p]  = 1'b1;
               end
            end
         end
         if (alloc_en[p]) begin
            free[alloc_idx[p]]       = 1'b0;
            alloc_vec[alloc_idx[p]]  = 1'b1;
            alloc_port[alloc_idx[p]] = PRT_W'(p);
         end
         push_haz[p] = resolve(bus.i_push_haz_typ[p], bus.i_push_haz_idx[p],
                               bus.i_push_cmt_id[p], bus.i_push_grp_id[p]);
      end
   end

   always_comb begin
      valid_n = '0;
      haz_n   = '0;
      age_n   = '0;
      cnt_n   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_n[i] = valid_q[i] && !(issue && sel[i]) && !i_flush_all && !br_kill(cmt_q[i], grp_q[i]);
         haz_n[i]   = resolve(typ_q[i], haz_q[i], cmt_q[i], grp_q[i]);
         if (alloc_vec[i]) valid_n[i] = 1'b1;
      end
      for (int p = 0; p < PUSH_NUM; p++) if (alloc_en[p]) haz_n[alloc_idx[p]] = push_haz[p];
      // new entries are younger than everything resident and than lower ports
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (alloc_vec[i]) age_n[i][j] = alloc_vec[j] && (alloc_port[j] > alloc_port[i]);
            else              age_n[i][j] = alloc_vec[j] ? 1'b1 : age_q[i][j];
         end
      end
      for (int i = 0; i < DEPTH; i++) cnt_n = cnt_n + CNT_W'(valid_n[i]);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid_q       <= '0;
         age_q         <= '0;
         haz_q         <= '0;
         cmt_q         <= '0;
         grp_q         <= '0;
         typ_q         <= '0;
         pld_q         <= '0;
         o_count       <= '0;
         o_full        <= 1'b0;
         o_almost_full <= 1'b0;
      end else begin
         valid_q       <= valid_n;
         age_q         <= age_n;
         haz_q         <= haz_n;
         o_count       <= cnt_n;
         o_full        <= (DEPTH - int'(cnt_n)) < PUSH_NUM;
         o_almost_full <= int'(cnt_n) >= (DEPTH - AF_MARGIN);
         for (int p = 0; p < PUSH_NUM; p++) begin
            if (alloc_en[p]) begin
               cmt_q[alloc_idx[p]] <= bus.i_push_cmt_id[p];
               grp_q[alloc_idx[p]] <= bus.i_push_grp_id[p];
               typ_q[alloc_idx[p]] <= bus.i_push_haz_typ[p];
               pld_q[alloc_idx[p]] <= bus.i_push_payload[p];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset_n) assert (!(o_full && (|bus.i_push_valid)));
   end
endmodule

// File: tb/tb_scariv_lsu_replay_queue_mp.sv
// Directed bench for the LSU replay queue; issued ops are checked against an
// expected-issue scoreboard filled as each op is made resolvable.
module tb_scariv_lsu_replay_queue_mp;
   localparam int DEPTH = 16, PUSH_NUM = 2, HAZ_W = 8, CMT_W = 6, GRP_W = 4, PLD_W = 64, AF_MARGIN = 4;

   typedef struct packed {
      logic [CMT_W-1:0] cmt;
      logic [PLD_W-1:0] pld;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_reset_n = 1'b0;
   logic o_full, o_almost_full;
   logic [$clog2(DEPTH+1)-1:0] o_count;
   logic [HAZ_W-1:0] i_stq_resolve = '0;
   logic i_missu_resolve_valid = 1'b0;
   logic [HAZ_W-1:0] i_missu_resolve_oh = '0;
   logic i_missu_full = 1'b1, i_missu_empty = 1'b1, i_st_buffer_empty = 1'b1;
   logic [CMT_W-1:0] i_oldest_cmt_id = '0;
   logic [GRP_W-1:0] i_oldest_grp_id = '0;
   logic i_flush_all = 1'b0, i_br_flush_valid = 1'b0;
   logic [CMT_W-1:0] i_br_flush_cmt_id = '0;
   logic [GRP_W-1:0] i_br_flush_grp_id = '0;

   int n_chk = 0, n_pass = 0;
   exp_t exp_q[$];

   scariv_lsu_replay_queue_mp_if #(.PUSH_NUM(PUSH_NUM), .HAZ_W(HAZ_W), .CMT_W(CMT_W),
                                   .GRP_W(GRP_W), .PLD_W(PLD_W)) bus ();

   scariv_lsu_replay_queue_mp #(.DEPTH(DEPTH), .PUSH_NUM(PUSH_NUM), .HAZ_W(HAZ_W), .CMT_W(CMT_W),
                                .GRP_W(GRP_W), .PLD_W(PLD_W), .AF_MARGIN(AF_MARGIN)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus.slave),
      .o_full(o_full), .o_almost_full(o_almost_full), .o_count(o_count),
      .i_stq_resolve(i_stq_resolve), .i_missu_resolve_valid(i_missu_resolve_valid),
      .i_missu_resolve_oh(i_missu_resolve_oh), .i_missu_full(i_missu_full),
      .i_missu_empty(i_missu_empty), .i_st_buffer_empty(i_st_buffer_empty),
      .i_oldest_cmt_id(i_oldest_cmt_id), .i_oldest_grp_id(i_oldest_grp_id),
      .i_flush_all(i_flush_all), .i_br_flush_valid(i_br_flush_valid),
      .i_br_flush_cmt_id(i_br_flush_cmt_id), .i_br_flush_grp_id(i_br_flush_grp_id)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [PLD_W-1:0] pld_of(input logic [CMT_W-1:0] cmt);
      return 64'hA5A5_0000_0000_0000 | 64'(cmt);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic expect_issue(input logic [CMT_W-1:0] cmt);
      exp_t e;
      e.cmt = cmt;
      e.pld = pld_of(cmt);
      exp_q.push_back(e);
   endtask

   task automatic push(input int p, input logic [CMT_W-1:0] cmt, input logic [GRP_W-1:0] grp,
                       input logic [2:0] typ, input logic [HAZ_W-1:0] haz);
      bus.i_push_valid[p]   = 1'b1;
      bus.i_push_cmt_id[p]  = cmt;
      bus.i_push_grp_id[p]  = grp;
      bus.i_push_haz_typ[p] = typ;
      bus.i_push_haz_idx[p] = haz;
      bus.i_push_payload[p] = pld_of(cmt);
   endtask

   task automatic clr_push();
      bus.i_push_valid = '0;
   endtask

   // one clock: handshakes are scored at the negedge, then inputs may change at posedge+1
   task automatic cycle();
      exp_t e;
      @(negedge i_clk);
      if (bus.o_req_valid && bus.i_req_ready) begin
         chk("issue_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_cmt", 64'(bus.o_req_cmt_id), 64'(e.cmt));
            chk("issue_pld", bus.o_req_payload, e.pld);
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      bus.i_push_valid   = '0;
      bus.i_push_cmt_id  = '0;
      bus.i_push_grp_id  = '0;
      bus.i_push_haz_typ = '0;
      bus.i_push_haz_idx = '0;
      bus.i_push_payload = '0;
      bus.i_req_ready    = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_count", 64'(o_count), 0);
      chk("rst_full", 64'(o_full), 0);
      chk("rst_af", 64'(o_almost_full), 0);
      chk("rst_req_valid", 64'(bus.o_req_valid), 0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;

      // single NONE op
      bus.i_req_ready = 1'b1;
      push(0, 6'd3, 4'd1, 3'd0, 8'h00);
      expect_issue(6'd3);
      cycle();
      clr_push();
      chk("none_req_valid", 64'(bus.o_req_valid), 1);
      chk("none_req_cmt", 64'(bus.o_req_cmt_id), 3);
      chk("none_count1", 64'(o_count), 1);
      cycle();
      chk("none_count0", 64'(o_count), 0);
      chk("none_req_idle", 64'(bus.o_req_valid), 0);

      // STQ A then B, released together, A first
      bus.i_req_ready = 1'b0;
      push(0, 6'd10, 4'd1, 3'd1, 8'h04);
      cycle();
      push(0, 6'd11, 4'd1, 3'd1, 8'h02);
      cycle();
      clr_push();
      chk("stq_count2", 64'(o_count), 2);
      chk("stq_blocked", 64'(bus.o_req_valid), 0);
      i_stq_resolve = 8'h06;
      expect_issue(6'd10);
      expect_issue(6'd11);
      cycle();
      i_stq_resolve = 8'h00;
      chk("stq_first", 64'(bus.o_req_cmt_id), 10);
      bus.i_req_ready = 1'b1;
      cycle();
      chk("stq_second", 64'(bus.o_req_cmt_id), 11);
      cycle();
      bus.i_req_ready = 1'b0;
      chk("stq_count0", 64'(o_count), 0);

      // reused low slot holds a younger op: age, not index, decides
      bus.i_req_ready = 1'b1;
      push(0, 6'd20, 4'd1, 3'd0, 8'h00);
      push(1, 6'd21, 4'd1, 3'd1, 8'h08);
      expect_issue(6'd20);
      cycle();
      clr_push();
      cycle();
      bus.i_req_ready = 1'b0;
      push(0, 6'd22, 4'd1, 3'd1, 8'h08);
      cycle();
      clr_push();
      i_stq_resolve = 8'h08;
      expect_issue(6'd21);
      expect_issue(6'd22);
      cycle();
      i_stq_resolve = 8'h00;
      chk("age_oldest", 64'(bus.o_req_cmt_id), 21);
      bus.i_req_ready = 1'b1;
      cycle();
      cycle();
      bus.i_req_ready = 1'b0;
      chk("age_count0", 64'(o_count), 0);

      // same-cycle wakeup bypass
      push(0, 6'd30, 4'd1, 3'd2, 8'h01);
      i_missu_resolve_valid = 1'b1;
      i_missu_resolve_oh = 8'h01;
      expect_issue(6'd30);
      cycle();
      clr_push();
      i_missu_resolve_valid = 1'b0;
      i_missu_resolve_oh = 8'h00;
      chk("bypass_valid", 64'(bus.o_req_valid), 1);
      chk("bypass_cmt", 64'(bus.o_req_cmt_id), 30);
      chk("bypass_typ", 64'(bus.o_req_haz_typ), 2);
      bus.i_req_ready = 1'b1;
      cycle();
      bus.i_req_ready = 1'b0;

      // MISSU_FULL waits for the miss unit to have room
      push(0, 6'd31, 4'd1, 3'd3, 8'h10);
      cycle();
      clr_push();
      cycle();
      chk("mfull_blocked", 64'(bus.o_req_valid), 0);
      i_missu_full = 1'b0;
      expect_issue(6'd31);
      cycle();
      i_missu_full = 1'b1;
      chk("mfull_ready", 64'(bus.o_req_cmt_id), 31);
      bus.i_req_ready = 1'b1;
      cycle();
      bus.i_req_ready = 1'b0;
      chk("mfull_count0", 64'(o_count), 0);

      // fill to DEPTH-PUSH_NUM+1
      for (int c = 0; c < 7; c++) begin
         push(0, 6'(40 + 2*c), 4'd1, 3'd0, 8'h00);
         push(1, 6'(41 + 2*c), 4'd1, 3'd0, 8'h00);
         expect_issue(6'(40 + 2*c));
         expect_issue(6'(41 + 2*c));
         cycle();
         if (c == 4) chk("fill_af_below", 64'(o_almost_full), 0);
         if (c == 5) chk("fill_af_at", 64'(o_almost_full), 1);
      end
      clr_push();
      chk("fill_full14", 64'(o_full), 0);
      push(0, 6'd54, 4'd1, 3'd0, 8'h00);
      expect_issue(6'd54);
      cycle();
      clr_push();
      chk("fill_count15", 64'(o_count), 15);
      chk("fill_full", 64'(o_full), 1);
      chk("fill_af", 64'(o_almost_full), 1);
      bus.i_req_ready = 1'b1;
      cycle();
      bus.i_req_ready = 1'b0;
      chk("fill_count14", 64'(o_count), 14);
      chk("fill_full_drop", 64'(o_full), 0);
      bus.i_req_ready = 1'b1;
      repeat (14) cycle();
      bus.i_req_ready = 1'b0;
      chk("fill_drained", 64'(o_count), 0);

      // branch flush across the wrap bit and on grp_id tie
      push(0, 6'd5, 4'd1, 3'd1, 8'h01);
      push(1, 6'd9, 4'd1, 3'd1, 8'h01);
      cycle();
      push(0, 6'h21, 4'd1, 3'd1, 8'h01);
      push(1, 6'd9, 4'd2, 3'd1, 8'h01);
      cycle();
      clr_push();
      chk("br_count4", 64'(o_count), 4);
      i_br_flush_valid = 1'b1;
      i_br_flush_cmt_id = 6'd9;
      i_br_flush_grp_id = 4'd1;
      push(0, 6'h22, 4'd1, 3'd0, 8'h00);
      cycle();
      clr_push();
      i_br_flush_valid = 1'b0;
      chk("br_count2", 64'(o_count), 2);
      chk("br_no_req", 64'(bus.o_req_valid), 0);
      i_stq_resolve = 8'h01;
      expect_issue(6'd5);
      expect_issue(6'd9);
      cycle();
      i_stq_resolve = 8'h00;
      bus.i_req_ready = 1'b1;
      repeat (3) cycle();
      bus.i_req_ready = 1'b0;
      chk("br_count0", 64'(o_count), 0);

      // RMW_ORDER waits for oldest + empty buffers
      bus.i_req_ready = 1'b1;
      i_st_buffer_empty = 1'b0;
      i_oldest_cmt_id = 6'd60;
      i_oldest_grp_id = 4'd1;
      push(0, 6'd60, 4'd1, 3'd4, 8'h01);
      cycle();
      clr_push();
      cycle();
      chk("rmw_blocked", 64'(bus.o_req_valid), 0);
      i_st_buffer_empty = 1'b1;
      expect_issue(6'd60);
      cycle();
      chk("rmw_ready", 64'(bus.o_req_valid), 1);
      chk("rmw_cmt", 64'(bus.o_req_cmt_id), 60);
      cycle();
      bus.i_req_ready = 1'b0;
      chk("rmw_count0", 64'(o_count), 0);

      // flush_all drops residents and same-cycle pushes
      push(0, 6'd12, 4'd1, 3'd0, 8'h00);
      push(1, 6'd13, 4'd1, 3'd0, 8'h00);
      cycle();
      clr_push();
      chk("fa_count2", 64'(o_count), 2);
      i_flush_all = 1'b1;
      push(0, 6'd14, 4'd1, 3'd0, 8'h00);
      cycle();
      clr_push();
      i_flush_all = 1'b0;
      chk("fa_count0", 64'(o_count), 0);
      chk("fa_no_req", 64'(bus.o_req_valid), 0);

      // async reset mid-operation
      push(0, 6'd15, 4'd1, 3'd1, 8'h01);
      push(1, 6'd16, 4'd1, 3'd1, 8'h01);
      cycle();
      clr_push();
      chk("rst2_count2", 64'(o_count), 2);
      #2 i_reset_n = 1'b0;
      #1;
      chk("rst2_count0", 64'(o_count), 0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      bus.i_req_ready = 1'b1;
      cycle();
      i_stq_resolve = 8'h01;
      cycle();
      i_stq_resolve = 8'h00;
      chk("rst2_no_req", 64'(bus.o_req_valid), 0);
      cycle();
      bus.i_req_ready = 1'b0;

      chk("sb_drained", 64'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
